// File: rtl/color_write_scheduler.sv
// Write-port scheduler for the 4x4 color grid: arbitrates the button and switch
// requesters, sweeps a full-grid clear, and only commits writes during blanking.
module color_write_scheduler #(
  parameter int unsigned CELLS = 16,
  parameter int unsigned CW    = 6
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          BlankIn,
  input  logic          BtnReq,
  input  logic [3:0]    BtnAddr,
  input  logic [CW-1:0] BtnColor,
  output logic          BtnAck,
  input  logic          SwReq,
  input  logic [3:0]    SwAddr,
  input  logic [CW-1:0] SwColor,
  output logic          SwAck,
  input  logic          ClearReq,
  input  logic [CW-1:0] ClearColor,
  output logic          ClearBusy,
  output logic          WrEn,
  output logic [3:0]    WrAddr,
  output logic [CW-1:0] WrData,
  output logic [1:0]    LastGrant
);

  localparam int unsigned AW = 4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] clr_color_q, clr_color_d;
  logic          clr_pend_q, clr_pend_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic          rr_sw_q, rr_sw_d;
  logic          mask_btn_q, mask_btn_d;
  logic          mask_sw_q, mask_sw_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0] wr_data_q, wr_data_d;
  logic          btn_ack_q, btn_ack_d;
  logic          sw_ack_q, sw_ack_d;
  logic [1:0]    last_grant_q, last_grant_d;

  logic new_clr, btn_ok, sw_ok, pick_sw;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clr_color_q  <= '0;
      clr_pend_q   <= 1'b0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      rr_sw_q      <= 1'b0;
      mask_btn_q   <= 1'b0;
      mask_sw_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      btn_ack_q    <= 1'b0;
      sw_ack_q     <= 1'b0;
      last_grant_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_color_q  <= clr_color_d;
      clr_pend_q   <= clr_pend_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      rr_sw_q      <= rr_sw_d;
      mask_btn_q   <= mask_btn_d;
      mask_sw_q    <= mask_sw_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      btn_ack_q    <= btn_ack_d;
      sw_ack_q     <= sw_ack_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clr_color_d  = clr_color_q;
    clr_pend_d   = clr_pend_q;
    clr_busy_d   = clr_busy_q;
    clr_done_d   = clr_done_q;
    rr_sw_d      = rr_sw_q;
    mask_btn_d   = 1'b0;
    mask_sw_d    = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    btn_ack_d    = 1'b0;
    sw_ack_d     = 1'b0;
    last_grant_d = last_grant_q;

    // ClearBusy already covers the pending window, so it alone gates new pulses
    new_clr = ClearReq && !clr_busy_q;
    btn_ok  = BtnReq && !mask_btn_q;
    sw_ok   = SwReq && !mask_sw_q;
    pick_sw = sw_ok && (!btn_ok || rr_sw_q);

    if (new_clr) begin
      clr_pend_d = 1'b1;
      clr_busy_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (BlankIn) begin
          if (clr_pend_q || new_clr) begin
            clr_pend_d  = 1'b0;
            clr_color_d = ClearColor;
            cnt_d       = '0;
            clr_done_d  = 1'b0;
            state_d     = CLEAR;
          end else if (btn_ok || sw_ok) begin
            state_d = WRITE;
            wr_en_d = 1'b1;
            if (pick_sw) begin
              wr_addr_d    = SwAddr;
              wr_data_d    = SwColor;
              sw_ack_d     = 1'b1;
              last_grant_d = 2'd2;
              rr_sw_d      = 1'b0;
            end else begin
              wr_addr_d    = BtnAddr;
              wr_data_d    = BtnColor;
              btn_ack_d    = 1'b1;
              last_grant_d = 2'd1;
              rr_sw_d      = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        // Hide the just-acked requester for one cycle while it drops Req
        mask_btn_d = btn_ack_q;
        mask_sw_d  = sw_ack_q;
        state_d    = IDLE;
      end
      CLEAR: begin
        if (clr_done_q) begin
          clr_busy_d   = 1'b0;
          clr_done_d   = 1'b0;
          last_grant_d = 2'd3;
          state_d      = IDLE;
        end else if (BlankIn) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = clr_color_q;
          if (cnt_q == LAST_ADDR) begin
            clr_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BtnAck    = btn_ack_q;
  assign SwAck     = sw_ack_q;
  assign ClearBusy = clr_busy_q;
  assign WrEn      = wr_en_q;
  assign WrAddr    = wr_addr_q;
  assign WrData    = wr_data_q;
  assign LastGrant = last_grant_q;

endmodule

// File: tb/tb_color_write_scheduler.sv
// Directed bench for color_write_scheduler with a scoreboard of expected writes.
module tb_color_write_scheduler;

  localparam int unsigned CW = 6;

  typedef struct packed {
    logic [3:0]    addr;
    logic [CW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  logic          CLK, Reset, BlankIn;
  logic          BtnReq, SwReq, ClearReq;
  logic [3:0]    BtnAddr, SwAddr;
  logic [CW-1:0] BtnColor, SwColor, ClearColor;
  logic          BtnAck, SwAck, ClearBusy, WrEn;
  logic [3:0]    WrAddr;
  logic [CW-1:0] WrData;
  logic [1:0]    LastGrant;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   clr_writes = 0;
  int   clr15_cyc = 0;

  color_write_scheduler #(.CELLS(16), .CW(CW)) dut (
    .CLK(CLK), .Reset(Reset), .BlankIn(BlankIn),
    .BtnReq(BtnReq), .BtnAddr(BtnAddr), .BtnColor(BtnColor), .BtnAck(BtnAck),
    .SwReq(SwReq), .SwAddr(SwAddr), .SwColor(SwColor), .SwAck(SwAck),
    .ClearReq(ClearReq), .ClearColor(ClearColor), .ClearBusy(ClearBusy),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .LastGrant(LastGrant)
  );

  initial begin
    CLK = 1'b0;
    forever #20 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [CW-1:0] d, input logic [1:0] s);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.src  = s;
    sb.push_back(e);
  endtask

  // Every write strobe must match the head of the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (Reset !== 1'b1) begin
      if (WrEn === 1'b1) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", 32'(WrAddr), 32'(e.addr));
          chk("wr_data", 32'(WrData), 32'(e.data));
          chk("wr_btn_ack", 32'(BtnAck), 32'(e.src == 2'd1));
          chk("wr_sw_ack", 32'(SwAck), 32'(e.src == 2'd2));
          if (e.src == 2'd3) begin
            clr_writes++;
            if (e.addr == 4'hF) clr15_cyc = cyc;
          end else begin
            chk("wr_last_grant", 32'(LastGrant), 32'(e.src));
            chk("wr_not_busy", 32'(ClearBusy), 32'd0);
          end
        end
      end else begin
        chk("idle_no_ack", 32'({BtnAck, SwAck}), 32'd0);
      end
    end
  end

  initial begin
    Reset = 1'b1; BlankIn = 1'b0;
    BtnReq = 1'b0; BtnAddr = '0; BtnColor = '0;
    SwReq = 1'b0; SwAddr = '0; SwColor = '0;
    ClearReq = 1'b0; ClearColor = '0;

    // Reset state
    tick(2);
    chk("rst_wren", 32'(WrEn), 32'd0);
    chk("rst_wraddr", 32'(WrAddr), 32'd0);
    chk("rst_wrdata", 32'(WrData), 32'd0);
    chk("rst_acks", 32'({BtnAck, SwAck}), 32'd0);
    chk("rst_busy", 32'(ClearBusy), 32'd0);
    chk("rst_lastgrant", 32'(LastGrant), 32'd0);
    Reset = 1'b0;
    tick(2);

    // Single button write, one-cycle latency
    BlankIn = 1'b1; BtnReq = 1'b1; BtnAddr = 4'h5; BtnColor = 6'h2A;
    push(4'h5, 6'h2A, 2'd1);
    tick(1);
    chk("btn_wren", 32'(WrEn), 32'd1);
    chk("btn_ack", 32'(BtnAck), 32'd1);
    chk("btn_addr", 32'(WrAddr), 32'h5);
    chk("btn_data", 32'(WrData), 32'h2A);
    chk("btn_lastgrant", 32'(LastGrant), 32'd1);
    BtnReq = 1'b0;
    tick(4);
    chk("btn_drain", 32'(sb.size()), 32'd0);

    // Switch request blocked by visible area, then granted one cycle after blank
    BlankIn = 1'b0; SwReq = 1'b1; SwAddr = 4'h9; SwColor = 6'h15;
    tick(100);
    chk("sw_blocked_wren", 32'(WrEn), 32'd0);
    push(4'h9, 6'h15, 2'd2);
    BlankIn = 1'b1;
    tick(1);
    chk("sw_ack_latency", 32'(SwAck), 32'd1);
    chk("sw_addr", 32'(WrAddr), 32'h9);
    SwReq = 1'b0;
    tick(3);
    chk("sw_drain", 32'(sb.size()), 32'd0);

    // Both held: round-robin Btn, Sw, Btn
    BtnReq = 1'b1; BtnAddr = 4'h3; BtnColor = 6'h11;
    SwReq = 1'b1; SwAddr = 4'hC; SwColor = 6'h22;
    push(4'h3, 6'h11, 2'd1);
    push(4'hC, 6'h22, 2'd2);
    push(4'h3, 6'h11, 2'd1);
    tick(5);
    BtnReq = 1'b0; SwReq = 1'b0;
    tick(4);
    chk("rr_drain", 32'(sb.size()), 32'd0);
    chk("rr_lastgrant", 32'(LastGrant), 32'd1);

    // Clear with a 5-cycle blank gap after the 8th write; button waits; 2nd pulse ignored
    clr_writes = 0;
    BlankIn = 1'b1; ClearColor = 6'h3F; ClearReq = 1'b1;
    BtnReq = 1'b1; BtnAddr = 4'h7; BtnColor = 6'h05;
    for (int i = 0; i < 16; i++) push(4'(i), 6'h3F, 2'd3);
    push(4'h7, 6'h05, 2'd1);
    tick(1);
    ClearReq = 1'b0;
    chk("clr_busy_rise", 32'(ClearBusy), 32'd1);
    chk("clr_wins_no_ack", 32'(BtnAck), 32'd0);
    for (int i = 0; i < 40 && clr_writes < 8; i++) begin
      @(negedge CLK); #1;
    end
    chk("clr_reach8", 32'(clr_writes), 32'd8);
    BlankIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) ClearReq = 1'b1;
      tick(1);
      ClearReq = 1'b0;
      chk("clr_gap_wren", 32'(WrEn), 32'd0);
    end
    chk("clr_gap_hold", 32'(clr_writes), 32'd8);
    BlankIn = 1'b1;
    for (int i = 0; i < 60 && ClearBusy !== 1'b0; i++) begin
      @(negedge CLK); #1;
    end
    chk("clr_busy_fall", 32'(ClearBusy), 32'd0);
    chk("clr_count16", 32'(clr_writes), 32'd16);
    chk("clr_lastgrant3", 32'(LastGrant), 32'd3);
    chk("clr_fall_cycle", 32'(cyc - clr15_cyc), 32'd1);
    for (int i = 0; i < 10 && BtnAck !== 1'b1; i++) begin
      @(negedge CLK); #1;
    end
    chk("btn_after_clear", 32'(BtnAck), 32'd1);
    BtnReq = 1'b0;
    tick(4);
    chk("clr_drain", 32'(sb.size()), 32'd0);
    chk("clr_single_sweep", 32'(clr_writes), 32'd16);

    // Async reset mid-clear aborts the sweep
    ClearColor = 6'h2A; ClearReq = 1'b1;
    for (int i = 0; i < 16; i++) push(4'(i), 6'h2A, 2'd3);
    tick(1);
    ClearReq = 1'b0;
    tick(4);
    @(negedge CLK); #5;
    sb.delete();
    Reset = 1'b1;
    #1;
    chk("abort_wren", 32'(WrEn), 32'd0);
    chk("abort_busy", 32'(ClearBusy), 32'd0);
    chk("abort_lastgrant", 32'(LastGrant), 32'd0);
    chk("abort_wraddr", 32'(WrAddr), 32'd0);
    chk("abort_wrdata", 32'(WrData), 32'd0);
    tick(1);
    Reset = 1'b0;
    tick(6);
    chk("abort_no_resume", 32'(ClearBusy), 32'd0);
    chk("abort_drain", 32'(sb.size()), 32'd0);

    // Pointer back to button after reset
    BtnReq = 1'b1; BtnAddr = 4'hE; BtnColor = 6'h30;
    SwReq = 1'b1; SwAddr = 4'h1; SwColor = 6'h0C;
    push(4'hE, 6'h30, 2'd1);
    tick(1);
    chk("ptr_reset_btn", 32'(BtnAck), 32'd1);
    BtnReq = 1'b0; SwReq = 1'b0;
    tick(4);
    chk("ptr_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/color_write_scheduler.md
# color_write_scheduler

Write-port scheduler for the 4x4 pixel color storage of the VGA display. Shares the storage write port between two requesters, the button-matrix painter and the switch/key editor, and runs a full-grid clear sequence. All writes are confined to vertical/horizontal blanking so the visible frame never tears. Sits between the input decoders and the color storage, in the 25 MHz pixel-clock domain.

## Interface
Parameters:
- CELLS, 16, number of grid cells swept by a clear (address width fixed at 4)
- CW, 6, color word width ({R[1:0],G[1:0],B[1:0]})

Ports:
- CLK  in  1  25 MHz pixel clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; one clock, reset async active-high
- BlankIn  in  1  1 = beam outside visible area, writes permitted
- BtnReq  in  1  button requester, level, held until BtnAck
- BtnAddr  in  4  {V[1:0],H[1:0]} target cell
- BtnColor  in  CW  color to write
- BtnAck  out  1  one-cycle pulse, request committed
- SwReq  in  1  switch/key requester, level, held until SwAck
- SwAddr  in  4  target cell
- SwColor  in  CW  color to write
- SwAck  out  1  one-cycle pulse, request committed
- ClearReq  in  1  single-cycle pulse, request full-grid clear
- ClearColor  in  CW  fill color, sampled when clear starts
- ClearBusy  out  1  high from clear acceptance until last cell written
- WrEn  out  1  storage write strobe
- WrAddr  out  4  storage write address
- WrData  out  CW  storage write data
- LastGrant  out  2  0 none, 1 button, 2 switch, 3 clear (debug LEDs)

## Operation
- States: IDLE, WRITE, CLEAR. Reset -> IDLE.
- ClearReq pulse sets clear-pending flag (any state). Pulses while pending or ClearBusy are ignored. ClearBusy rises the cycle after the pulse.
- IDLE, BlankIn=0: no action, all requests wait.
- IDLE, BlankIn=1, priority: clear-pending > requesters.
  - clear-pending: latch ClearColor, counter=0, clear flag, -> CLEAR.
  - else one requester high: capture its addr/color -> WRITE.
  - both high: round-robin pointer picks; pointer toggles to the other source after each grant. Pointer resets to button.
- WRITE (1 cycle): WrEn=1 with captured addr/data, matching Ack=1, LastGrant updated. -> IDLE.
- Acked requester is masked for the cycle after its Ack; requester must drop Req by then. Req still high two cycles after Ack = new request.
- CLEAR: each cycle with BlankIn=1: WrEn=1, WrAddr=counter, WrData=latched color, counter+1. BlankIn=0: WrEn=0, counter held (sweep pauses, resumes at same address). After address CELLS-1 written: ClearBusy=0 next cycle, LastGrant=3, -> IDLE.
- Requests arriving during CLEAR wait; no Ack until clear completes.
- Counter is 4 bits; no wrap beyond CELLS-1 (exit condition, not overflow).

## Timing
- Reset values: WrEn=0, WrAddr=0, WrData=0, BtnAck=0, SwAck=0, ClearBusy=0, LastGrant=0, pointer=button, clear-pending=0.
- All outputs registered.
- Request latency: Req and BlankIn high at edge n -> WrEn/Ack high during cycle n+1. Write in n+1 commits even if BlankIn fell at n+1 (storage is latched; tearing bounded to one cell).
- Clear: 16 write cycles of blank time minimum; first write cycle after acceptance edge.
- Max throughput: one write per 2 cycles per requester path (WRITE -> IDLE), one per cycle during CLEAR.
- Reset mid-CLEAR or mid-WRITE: aborts immediately, pending clear discarded, partial grid not restored.
- ClearReq and a Req on same edge in IDLE with BlankIn=1: clear wins; Req waits.

## Test plan
- Reset asserted async mid-cycle -> all outputs 0 within that cycle, LastGrant=0.
- BtnReq=1, BtnAddr=4'h5, BtnColor=6'h2A, BlankIn=1 at edge n -> cycle n+1 WrEn=1, WrAddr=5, WrData=2A, BtnAck=1, LastGrant=1; nothing further with Req dropped.
- BtnReq and SwReq both held, BlankIn=1 -> acks alternate Btn, Sw, Btn; WrAddr matches granted source each time.
- SwReq=1 with BlankIn=0 for 100 cycles -> no WrEn; BlankIn rises -> SwAck exactly one cycle later.
- ClearReq pulse, ClearColor=6'h3F, BlankIn=1 except 5-cycle gap after 8th write -> WrAddr 0..15 with WrEn=1, pause at 8 during gap, ClearBusy falls after address 15, 16 writes total.
- BtnReq held during clear -> BtnAck only after ClearBusy falls; second ClearReq during clear -> ignored (exactly 16 writes).
